// File: rtl/sp128_ram_ctrl.sv
// sp128_ram_ctrl: valid/ready front end and array-fill sequencer for a 128x8 single-port RAM
// Ports: clk/reset_n; req_valid/req_ready/req_we/req_addr/req_wdata request stream;
//        rsp_valid/rsp_rdata read response; clear_start/busy array fill control;
//        ram_ce/ram_wre/ram_ad/ram_din registered strobes, ram_oce/ram_reset tie-offs, ram_dout read data.
module sp128_ram_ctrl #(
  parameter logic [7:0] CLEAR_VAL      = 8'h00,
  parameter bit         CLEAR_ON_RESET = 1'b1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_we,
  input  logic [6:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  input  logic       clear_start,
  output logic       busy,
  output logic       ram_ce,
  output logic       ram_wre,
  output logic       ram_oce,
  output logic       ram_reset,
  output logic [6:0] ram_ad,
  output logic [7:0] ram_din,
  input  logic [7:0] ram_dout
);
  typedef enum logic [1:0] {IDLE, RD1, RD2, CLEAR} state_t;
  state_t state, state_n;
  logic pend, pend_n, ce_n, wre_n, rv_n, accept, go;
  logic [6:0] ad_n;
  logic [7:0] din_n, rdata_n;
  assign req_ready = state == IDLE && !pend;
  assign busy      = state == CLEAR;
  assign ram_oce   = 1'b1;
  assign ram_reset = 1'b0;
  assign accept    = req_valid && req_ready;
  // A fresh clear_start launches the fill at once unless it collides with an accepted request; then it waits in pend.
  assign go = state == IDLE && (pend || (clear_start && !accept));
  always_comb begin
    state_n = state;
    pend_n  = go ? 1'b0 : pend || (clear_start && state != CLEAR);
    ce_n    = 1'b0;
    wre_n   = 1'b0;
    ad_n    = ram_ad;
    din_n   = ram_din;
    rv_n    = 1'b0;
    rdata_n = rsp_rdata;
    case (state)
      IDLE: begin
        if (go) begin
          state_n = CLEAR;
          ce_n    = 1'b1;
          wre_n   = 1'b1;
          ad_n    = 7'd0;
          din_n   = CLEAR_VAL;
        end else if (accept) begin
          state_n = req_we ? IDLE : RD1;
          ce_n    = 1'b1;
          wre_n   = req_we;
          ad_n    = req_addr;
          din_n   = req_we ? req_wdata : ram_din;
        end
      end
      RD1: state_n = RD2;
      RD2: begin
        state_n = IDLE;
        rv_n    = 1'b1;
        rdata_n = ram_dout;
      end
      default: begin
        // ram_ce is low in CLEAR only on the first cycle out of reset, so that fill starts at address 0
        if (ram_ce && ram_ad == 7'h7f) begin
          state_n = IDLE;
        end else begin
          ce_n  = 1'b1;
          wre_n = 1'b1;
          ad_n  = ram_ce ? ram_ad + 7'd1 : 7'd0;
          din_n = CLEAR_VAL;
        end
      end
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= CLEAR_ON_RESET ? CLEAR : IDLE;
      pend      <= 1'b0;
      ram_ce    <= 1'b0;
      ram_wre   <= 1'b0;
      ram_ad    <= 7'd0;
      ram_din   <= 8'd0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 8'd0;
    end else begin
      state     <= state_n;
      pend      <= pend_n;
      ram_ce    <= ce_n;
      ram_wre   <= wre_n;
      ram_ad    <= ad_n;
      ram_din   <= din_n;
      rsp_valid <= rv_n;
      rsp_rdata <= rdata_n;
    end
  end
endmodule

// File: tb/tb_sp128_ram_ctrl.sv
// tb_sp128_ram_ctrl: scoreboard bench for sp128_ram_ctrl with a clear-on-reset and an idle-on-reset instance
module tb_sp128_ram_ctrl;
  localparam logic [7:0] CV_A = 8'h00;
  localparam logic [7:0] CV_B = 8'h3C;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_a, rst_b, sel, req_valid, req_we, clear_start;
  logic [6:0] req_addr;
  logic [7:0] req_wdata;
  logic a_ready, a_rv, a_busy, a_ce, a_wre, a_oce, a_rr;
  logic b_ready, b_rv, b_busy, b_ce, b_wre, b_oce, b_rr;
  logic [6:0] a_ad, b_ad;
  logic [7:0] a_rdata, a_din, a_dout, b_rdata, b_din, b_dout;
  logic [7:0] mem_a [128];
  logic [7:0] mem_b [128];
  logic ready, rv, busy, ce, wre;
  logic [6:0] ad;
  logic [7:0] rdata, din;
  sp128_ram_ctrl u_a (
    .clk(clk), .reset_n(rst_a), .req_valid(req_valid & ~sel), .req_ready(a_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(a_rv), .rsp_rdata(a_rdata),
    .clear_start(clear_start & ~sel), .busy(a_busy), .ram_ce(a_ce), .ram_wre(a_wre), .ram_oce(a_oce),
    .ram_reset(a_rr), .ram_ad(a_ad), .ram_din(a_din), .ram_dout(a_dout)
  );
  sp128_ram_ctrl #(.CLEAR_VAL(CV_B), .CLEAR_ON_RESET(1'b0)) u_b (
    .clk(clk), .reset_n(rst_b), .req_valid(req_valid & sel), .req_ready(b_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(b_rv), .rsp_rdata(b_rdata),
    .clear_start(clear_start & sel), .busy(b_busy), .ram_ce(b_ce), .ram_wre(b_wre), .ram_oce(b_oce),
    .ram_reset(b_rr), .ram_ad(b_ad), .ram_din(b_din), .ram_dout(b_dout)
  );
  always @(posedge clk) if (a_ce) begin
    if (a_wre) mem_a[a_ad] <= a_din;
    else a_dout <= mem_a[a_ad];
  end
  always @(posedge clk) if (b_ce) begin
    if (b_wre) mem_b[b_ad] <= b_din;
    else b_dout <= mem_b[b_ad];
  end
  assign ready = sel ? b_ready : a_ready;
  assign rv    = sel ? b_rv    : a_rv;
  assign busy  = sel ? b_busy  : a_busy;
  assign ce    = sel ? b_ce    : a_ce;
  assign wre   = sel ? b_wre   : a_wre;
  assign ad    = sel ? b_ad    : a_ad;
  assign rdata = sel ? b_rdata : a_rdata;
  assign din   = sel ? b_din   : a_din;
  typedef struct {logic [7:0] d; int due;} exp_t;
  exp_t exp_q[$];
  int total = 0, bad = 0, cyc = 0;
  logic [7:0] ref_m [2][128];
  logic rv_q = 1'b0;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (rv) begin
      if (exp_q.size() == 0) chk("rsp_unexpected", 1, 0);
      else begin
        e = exp_q.pop_front();
        chk("rsp_data", rdata, e.d);
        chk("rsp_latency", cyc, e.due);
      end
      chk("rsp_pulse", rv_q, 0);
    end
    rv_q <= rv;
  end
  task automatic issue(input logic we, input logic [6:0] a, input logic [7:0] d, output int acc);
    int n = 0;
    acc = -1;
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
    while (!ready && n < 400) begin @(negedge clk); n++; end
    if (!ready) begin chk("accept_timeout", 0, 1); return; end
    acc = cyc;
    if (we) ref_m[sel][a] = d;
    else exp_q.push_back('{ref_m[sel][a], cyc + 3});
    @(posedge clk);
    @(negedge clk);
    if (we) chk("wr_strobe", {ce, wre, ad, din}, {2'b11, a, d});
    else begin
      chk("rd_strobe", {ce, wre, ad}, {2'b10, a});
      chk("rd_ready_low", ready, 0);
    end
  endtask
  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 20) begin @(negedge clk); n++; end
    chk("drain", exp_q.size(), 0);
  endtask
  task automatic check_clear(input logic [7:0] cv, input int poke);
    int good = 0;
    for (int k = 0; k < 128; k++) begin
      @(negedge clk);
      if (ce && wre && ad == 7'(k) && din == cv && busy && !ready) good++;
      clear_start = (k == poke);
    end
    chk("clear_strobes", good, 128);
    for (int k = 0; k < 128; k++) ref_m[sel][k] = cv;
    @(negedge clk);
    chk("clear_done", {busy, ready, ce}, 3'b010);
  endtask
  initial begin
    int a0, a1, a2, n;
    rst_a = 1'b0; rst_b = 1'b0; sel = 1'b0; req_valid = 1'b0; req_we = 1'b0;
    req_addr = 7'd0; req_wdata = 8'd0; clear_start = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_a_outs", {a_ce, a_wre, a_ad, a_din, a_rv, a_rdata}, 0);
    chk("rst_a_stat", {a_busy, a_ready, a_oce, a_rr}, 4'b1010);
    chk("rst_b_stat", {b_busy, b_ready, b_oce, b_rr}, 4'b0110);
    rst_a = 1'b1; rst_b = 1'b1;
    check_clear(CV_A, -1);
    issue(1'b0, 7'h7f, 8'h00, a0); req_valid = 1'b0;
    drain();
    issue(1'b1, 7'h10, 8'hA5, a0);
    issue(1'b1, 7'h11, 8'h5A, a1);
    req_valid = 1'b0;
    chk("wr_b2b", a1 - a0, 1);
    issue(1'b0, 7'h10, 8'h00, a0);
    issue(1'b0, 7'h11, 8'h00, a1);
    issue(1'b0, 7'h10, 8'h00, a2);
    req_valid = 1'b0;
    chk("rd_spacing1", a1 - a0, 3);
    chk("rd_spacing2", a2 - a1, 3);
    drain();
    clear_start = 1'b1;
    issue(1'b0, 7'h10, 8'h00, a0);
    clear_start = 1'b0; req_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("rsp_before_clear", {rv, rdata, ready, busy}, {1'b1, 8'hA5, 2'b00});
    check_clear(CV_A, -1);
    issue(1'b0, 7'h10, 8'h00, a0); req_valid = 1'b0;
    drain();
    issue(1'b1, 7'h20, 8'h77, a0); req_valid = 1'b0;
    clear_start = 1'b1;
    check_clear(CV_A, 60);
    n = 0;
    repeat (4) begin @(negedge clk); n += int'(ce) + int'(busy); end
    chk("no_second_pass", n, 0);
    issue(1'b0, 7'h20, 8'h00, a0); req_valid = 1'b0;
    drain();
    sel = 1'b1;
    issue(1'b1, 7'd39, 8'h44, a0);
    issue(1'b1, 7'd41, 8'h11, a0);
    issue(1'b1, 7'd100, 8'h22, a0);
    issue(1'b1, 7'd127, 8'h33, a0);
    req_valid = 1'b0;
    clear_start = 1'b1;
    @(negedge clk);
    clear_start = 1'b0;
    n = 0;
    while (!(ce && ad == 7'd40) && n < 200) begin @(negedge clk); n++; end
    chk("reach_ad40", {ce, ad}, {1'b1, 7'd40});
    rst_b = 1'b0;
    #1;
    chk("rst_mid_clear", {ce, wre, busy, rv}, 0);
    chk("rst_ready", ready, 1);
    @(negedge clk);
    rst_b = 1'b1;
    @(negedge clk);
    chk("post_rst", {busy, ready, ce}, 3'b010);
    for (int k = 0; k < 40; k++) ref_m[1][k] = CV_B;
    issue(1'b0, 7'd39, 8'h00, a0);
    issue(1'b0, 7'd41, 8'h00, a0);
    issue(1'b0, 7'd100, 8'h00, a0);
    issue(1'b0, 7'd127, 8'h00, a0);
    req_valid = 1'b0;
    drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
